// File: rtl/msf_pkg.sv
// Shared types and frame-layout constants for the MSF minute-frame sequencer.
package msf_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  // A-bit positions of the BCD fields; MSB is the first second transmitted
  localparam int unsigned YEAR_MSB  = 17;
  localparam int unsigned YEAR_LSB  = 24;
  localparam int unsigned MONTH_MSB = 25;
  localparam int unsigned MONTH_LSB = 29;
  localparam int unsigned DAY_MSB   = 30;
  localparam int unsigned DAY_LSB   = 35;
  localparam int unsigned DOW_MSB   = 36;
  localparam int unsigned DOW_LSB   = 38;
  localparam int unsigned HOUR_MSB  = 39;
  localparam int unsigned HOUR_LSB  = 44;
  localparam int unsigned MIN_MSB   = 45;
  localparam int unsigned MIN_LSB   = 51;

  // Odd-parity groups: A range plus the covering B bit
  localparam int unsigned PAR_YEAR_LO = 17;
  localparam int unsigned PAR_YEAR_HI = 24;
  localparam int unsigned PAR_YEAR_B  = 54;
  localparam int unsigned PAR_DATE_LO = 25;
  localparam int unsigned PAR_DATE_HI = 35;
  localparam int unsigned PAR_DATE_B  = 55;
  localparam int unsigned PAR_DOW_LO  = 36;
  localparam int unsigned PAR_DOW_HI  = 38;
  localparam int unsigned PAR_DOW_B   = 56;
  localparam int unsigned PAR_TIME_LO = 39;
  localparam int unsigned PAR_TIME_HI = 51;
  localparam int unsigned PAR_TIME_B  = 57;

  localparam int unsigned MARK_FIRST = 52;
  localparam int unsigned MARK_LAST  = 59;
  localparam logic [7:0]  MARKER_PATTERN = 8'h7E;

endpackage

// File: rtl/msf_parity_check.sv
// Combinational frame validation: four odd-parity groups and the A52..A59 marker.
module msf_parity_check
  import msf_pkg::*;
(
  input  logic [59:1] a_sr,
  input  logic [59:1] b_sr,
  output logic [3:0]  parity_ok,
  output logic        marker_ok
);

  logic [7:0] marker_bits;
  logic       unused_bits;

  assign parity_ok[0] = ^{a_sr[PAR_YEAR_HI:PAR_YEAR_LO], b_sr[PAR_YEAR_B]};
  assign parity_ok[1] = ^{a_sr[PAR_DATE_HI:PAR_DATE_LO], b_sr[PAR_DATE_B]};
  assign parity_ok[2] = ^{a_sr[PAR_DOW_HI:PAR_DOW_LO],   b_sr[PAR_DOW_B]};
  assign parity_ok[3] = ^{a_sr[PAR_TIME_HI:PAR_TIME_LO], b_sr[PAR_TIME_B]};

  // A52 lands in the MSB of the compared pattern
  assign marker_bits = {<<{a_sr[MARK_LAST:MARK_FIRST]}};
  assign marker_ok   = (marker_bits == MARKER_PATTERN);

  assign unused_bits = ^{a_sr[PAR_YEAR_LO-1:1], b_sr[PAR_YEAR_B-1:1], b_sr[59:PAR_TIME_B+1]};

endmodule

// File: rtl/msf_frame_sequencer.sv
// Assembles decoded MSF seconds into minute frames and publishes validated BCD time/date.
// Optional saturating frame-error counter when MSF_STATS_EN is defined.
module msf_frame_sequencer
  import msf_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 60
`ifdef MSF_STATS_EN
  , parameter int unsigned ERR_CNT_W = 8
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic [5:0] second_o,
  output logic       locked_o,
  output logic       time_valid_o,
  output logic [7:0] year_o,
  output logic [4:0] month_o,
  output logic [5:0] day_o,
  output logic [2:0] dow_o,
  output logic [5:0] hour_o,
  output logic [6:0] minute_o,
  output logic       frame_err_o
`ifdef MSF_STATS_EN
  , output logic [ERR_CNT_W-1:0] err_count_o
`endif
);

  localparam logic [5:0] LAST_SEC = 6'(FRAME_LEN - 1);

  state_e      state;
  logic [59:1] a_sr;
  logic [59:1] b_sr;
  logic [3:0]  parity_ok;
  logic        marker_ok;
  logic        frame_ok;
  logic [5:0]  wr_idx;

  logic [7:0]  year_c;
  logic [4:0]  month_c;
  logic [5:0]  day_c;
  logic [2:0]  dow_c;
  logic [5:0]  hour_c;
  logic [6:0]  minute_c;

  msf_parity_check u_parity (
    .a_sr      (a_sr),
    .b_sr      (b_sr),
    .parity_ok (parity_ok),
    .marker_ok (marker_ok)
  );

  assign frame_ok = marker_ok & (&parity_ok);
  assign wr_idx   = second_o + 6'd1;

  // Bit-reverse each slice so the earliest-transmitted second becomes the field MSB
  assign year_c   = {<<{a_sr[YEAR_LSB:YEAR_MSB]}};
  assign month_c  = {<<{a_sr[MONTH_LSB:MONTH_MSB]}};
  assign day_c    = {<<{a_sr[DAY_LSB:DAY_MSB]}};
  assign dow_c    = {<<{a_sr[DOW_LSB:DOW_MSB]}};
  assign hour_c   = {<<{a_sr[HOUR_LSB:HOUR_MSB]}};
  assign minute_c = {<<{a_sr[MIN_LSB:MIN_MSB]}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_HUNT;
      second_o     <= 6'd0;
      locked_o     <= 1'b0;
      time_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      year_o       <= 8'd0;
      month_o      <= 5'd0;
      day_o        <= 6'd0;
      dow_o        <= 3'd0;
      hour_o       <= 6'd0;
      minute_o     <= 7'd0;
      a_sr         <= '0;
      b_sr         <= '0;
    end else begin
      time_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (bits_valid_i && bits_is_second_00_i) begin
            state    <= ST_COLLECT;
            second_o <= 6'd0;
            locked_o <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (bits_valid_i) begin
            if (bits_is_second_00_i) begin
              if (second_o == LAST_SEC) begin
                state <= ST_CHECK;
              end else begin
                // Early marker: drop the partial frame, the marker opens a new one
                frame_err_o <= 1'b1;
                second_o    <= 6'd0;
              end
            end else if (second_o == LAST_SEC) begin
              // Overlong minute (missing marker or leap second)
              frame_err_o <= 1'b1;
              second_o    <= 6'd0;
              locked_o    <= 1'b0;
              state       <= ST_HUNT;
            end else begin
              second_o     <= wr_idx;
              a_sr[wr_idx] <= bits_data_i[1];
              b_sr[wr_idx] <= bits_data_i[0];
            end
          end
        end
        ST_CHECK: begin
          state    <= ST_COLLECT;
          second_o <= 6'd0;
          if (frame_ok) begin
            time_valid_o <= 1'b1;
            year_o       <= year_c;
            month_o      <= month_c;
            day_o        <= day_c;
            dow_o        <= dow_c;
            hour_o       <= hour_c;
            minute_o     <= minute_c;
          end else begin
            frame_err_o <= 1'b1;
          end
        end
        default: begin
          state    <= ST_HUNT;
          second_o <= 6'd0;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef MSF_STATS_EN
  // Counts frame_err_o pulses, sticking at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_o <= '0;
    end else if (frame_err_o && (err_count_o != {ERR_CNT_W{1'b1}})) begin
      err_count_o <= err_count_o + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_msf_frame_sequencer.sv
// Scoreboard bench for msf_frame_sequencer: frame-level reference model, randomized frames.
module tb_msf_frame_sequencer;

  logic       clk;
  logic       rst_ni;
  logic       bits_valid_i;
  logic       bits_is_second_00_i;
  logic [1:0] bits_data_i;
  logic [5:0] second_o;
  logic       locked_o;
  logic       time_valid_o;
  logic [7:0] year_o;
  logic [4:0] month_o;
  logic [5:0] day_o;
  logic [2:0] dow_o;
  logic [5:0] hour_o;
  logic [6:0] minute_o;
  logic       frame_err_o;
`ifdef MSF_STATS_EN
  logic [7:0] err_count_o;
`endif

  msf_frame_sequencer dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .bits_valid_i        (bits_valid_i),
    .bits_is_second_00_i (bits_is_second_00_i),
    .bits_data_i         (bits_data_i),
    .second_o            (second_o),
    .locked_o            (locked_o),
    .time_valid_o        (time_valid_o),
    .year_o              (year_o),
    .month_o             (month_o),
    .day_o               (day_o),
    .dow_o               (dow_o),
    .hour_o              (hour_o),
    .minute_o            (minute_o),
    .frame_err_o         (frame_err_o)
`ifdef MSF_STATS_EN
    , .err_count_o       (err_count_o)
`endif
  );

  typedef struct {
    bit tv;
    int cyc;
    int year, month, day, dow, hour, minute;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Frame under construction (index = second number)
  bit fa[60];
  bit fb[60];

  // Reference model state
  bit m_a[60];
  bit m_b[60];
  bit m_locked;
  int m_sec;
  int m_year, m_month, m_day, m_dow, m_hour, m_minute;
  int m_errs;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic put(input int msb, input int w, input int v);
    for (int i = 0; i < w; i++) fa[msb + i] = 1'((v >> (w - 1 - i)) & 1);
  endtask

  // B bit value that makes the group's total number of ones odd
  function automatic bit par_bit(input int lo, input int hi);
    int cnt = 0;
    for (int i = lo; i <= hi; i++) cnt += int'(fa[i]);
    return (cnt % 2) == 0;
  endfunction

  task automatic gen_frame(input int yr, input int mo, input int dy, input int dw,
                           input int hr, input int mi);
    for (int i = 0; i < 60; i++) begin
      fa[i] = 1'($urandom);
      fb[i] = 1'($urandom);
    end
    put(17, 8, bcd(yr));
    put(25, 5, bcd(mo));
    put(30, 6, bcd(dy));
    put(36, 3, dw);
    put(39, 6, bcd(hr));
    put(45, 7, bcd(mi));
    fa[52] = 1'b0;
    for (int i = 53; i <= 58; i++) fa[i] = 1'b1;
    fa[59] = 1'b0;
    fb[54] = par_bit(17, 24);
    fb[55] = par_bit(25, 35);
    fb[56] = par_bit(36, 38);
    fb[57] = par_bit(39, 51);
  endtask

  function automatic int fld(input int msb, input int w);
    int v = 0;
    for (int i = 0; i < w; i++) v = v * 2 + int'(m_a[msb + i]);
    return v;
  endfunction

  function automatic bit grp_ok(input int lo, input int hi, input int bi);
    int cnt = int'(m_b[bi]);
    for (int i = lo; i <= hi; i++) cnt += int'(m_a[i]);
    return (cnt % 2) == 1;
  endfunction

  function automatic bit frame_good();
    bit ok = (m_a[52] == 1'b0) && (m_a[59] == 1'b0);
    for (int i = 53; i <= 58; i++) ok = ok && m_a[i];
    return ok && grp_ok(17, 24, 54) && grp_ok(25, 35, 55) &&
           grp_ok(36, 38, 56) && grp_ok(39, 51, 57);
  endfunction

  task automatic push(input bit tv, input int lat);
    exp_t x;
    x.tv = tv; x.cyc = cyc + lat;
    x.year = m_year; x.month = m_month; x.day = m_day;
    x.dow = m_dow; x.hour = m_hour; x.minute = m_minute;
    q.push_back(x);
    if (!tv && m_errs != 255) m_errs++;
  endtask

  // One decoded second in terms of minute-frame rules
  task automatic model_step(input bit mk, input bit a, input bit b);
    if (!m_locked) begin
      if (mk) begin
        m_locked = 1'b1;
        m_sec = 0;
      end
    end else if (mk) begin
      if (m_sec == 59) begin
        if (frame_good()) begin
          m_year = fld(17, 8); m_month = fld(25, 5); m_day = fld(30, 6);
          m_dow = fld(36, 3); m_hour = fld(39, 6); m_minute = fld(45, 7);
          push(1'b1, 2);
        end else begin
          push(1'b0, 2);
        end
      end else begin
        push(1'b0, 1);
      end
      m_sec = 0;
    end else if (m_sec == 59) begin
      push(1'b0, 1);
      m_locked = 1'b0;
      m_sec = 0;
    end else begin
      m_sec++;
      m_a[m_sec] = a;
      m_b[m_sec] = b;
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_sec = 0; m_errs = 0;
    m_year = 0; m_month = 0; m_day = 0; m_dow = 0; m_hour = 0; m_minute = 0;
  endtask

  task automatic send(input bit mk, input bit a, input bit b);
    @(posedge clk); #1;
    chk("second", 32'(second_o), m_sec);
    chk("locked", 32'(locked_o), 32'(m_locked));
    bits_valid_i = 1'b1;
    bits_is_second_00_i = mk;
    bits_data_i = {a, b};
    model_step(mk, a, b);
    @(posedge clk); #1;
    bits_valid_i = 1'b0;
    bits_is_second_00_i = 1'b0;
    bits_data_i = 2'($urandom);
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic play(input int n);
    for (int s = 1; s <= n; s++) begin
      if (s <= 59) send(1'b0, fa[s], fb[s]);
      else send(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic chk_fields(input string tag, input int yr, input int mo, input int dy,
                            input int dw, input int hr, input int mi);
    chk({tag, "_year"},   32'(year_o),   yr);
    chk({tag, "_month"},  32'(month_o),  mo);
    chk({tag, "_day"},    32'(day_o),    dy);
    chk({tag, "_dow"},    32'(dow_o),    dw);
    chk({tag, "_hour"},   32'(hour_o),   hr);
    chk({tag, "_minute"}, 32'(minute_o), mi);
  endtask

  // Monitor: every output pulse must match the oldest expected event, on time
  always @(negedge clk) begin
    if (rst_ni) begin
      if (time_valid_o || frame_err_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: time_valid=%0d frame_err=%0d with nothing expected at t=%0t",
                   time_valid_o, frame_err_o, $time);
        end else begin
          e = q.pop_front();
          chk("pulse_time_valid", 32'(time_valid_o), 32'(e.tv));
          chk("pulse_frame_err", 32'(frame_err_o), 32'(!e.tv));
          chk("pulse_cycle", cyc, e.cyc);
          chk_fields("pulse", e.year, e.month, e.day, e.dow, e.hour, e.minute);
        end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        chk("pulse_missing", 32'(time_valid_o | frame_err_o), 32'd1);
      end
    end
  end

  initial begin
    int n;
    rst_ni = 1'b0;
    bits_valid_i = 1'b0;
    bits_is_second_00_i = 1'b0;
    bits_data_i = 2'd0;
    model_reset();
    #1;
    chk("rst_second", 32'(second_o), 0);
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_time_valid", 32'(time_valid_o), 0);
    chk("rst_frame_err", 32'(frame_err_o), 0);
    chk_fields("rst", 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Stray seconds before any marker are ignored
    for (int i = 0; i < 5; i++) send(1'b0, 1'($urandom), 1'($urandom));
    settle();
    chk("hunt_second", 32'(second_o), 0);
    chk("hunt_locked", 32'(locked_o), 0);
    chk_fields("hunt", 0, 0, 0, 0, 0, 0);

    // Valid frame 24-03-15 Fri 13:47
    send(1'b1, 1'b0, 1'b0);
    gen_frame(24, 3, 15, 5, 13, 47);
    play(59);
    send(1'b1, 1'b0, 1'b0);
    settle();
    chk_fields("t1", 'h24, 'h03, 'h15, 5, 'h13, 'h47);

    // Same frame with B55 flipped
    fb[55] = !fb[55];
    play(59);
    send(1'b1, 1'b0, 1'b0);
    settle();
    chk_fields("t2", 'h24, 'h03, 'h15, 5, 'h13, 'h47);

    // Early marker after 30 s, then a full good frame
    gen_frame(99, 12, 31, 6, 23, 59);
    play(30);
    send(1'b1, 1'b0, 1'b0);
    play(59);
    send(1'b1, 1'b0, 1'b0);
    settle();
    chk_fields("t3", 'h99, 'h12, 'h31, 6, 'h23, 'h59);

    // 60 seconds with no marker drops back to hunting
    play(60);
    settle();
    chk("t4_locked", 32'(locked_o), 0);
    chk("t4_second", 32'(second_o), 0);

    // Randomized frames: good, corrupted, short and overlong
    for (int it = 0; it < 20; it++) begin
      gen_frame($urandom_range(0, 99), $urandom_range(1, 12), $urandom_range(1, 31),
                $urandom_range(0, 6), $urandom_range(0, 23), $urandom_range(0, 59));
      if ($urandom_range(0, 3) == 0) begin
        int p = $urandom_range(17, 59);
        fa[p] = !fa[p];
      end
      case ($urandom_range(0, 7))
        0: n = $urandom_range(0, 58);
        1: n = 60;
        default: n = 59;
      endcase
      if (!m_locked) begin
        repeat ($urandom_range(0, 2)) send(1'b0, 1'($urandom), 1'($urandom));
        send(1'b1, 1'b0, 1'b0);
      end
      play(n);
      if (n <= 59) send(1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a frame
    if (!m_locked) send(1'b1, 1'b0, 1'b0);
    gen_frame(1, 1, 1, 0, 0, 0);
    play(37);
    settle();
    chk("pre_rst_second", 32'(second_o), 37);
    chk("pre_rst_queue", 32'(q.size()), 0);
`ifdef MSF_STATS_EN
    chk("pre_rst_err_count", 32'(err_count_o), m_errs);
`endif
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_second", 32'(second_o), 0);
    chk("mid_rst_locked", 32'(locked_o), 0);
    chk("mid_rst_time_valid", 32'(time_valid_o), 0);
    chk("mid_rst_frame_err", 32'(frame_err_o), 0);
    chk_fields("mid_rst", 0, 0, 0, 0, 0, 0);
`ifdef MSF_STATS_EN
    chk("mid_rst_err_count", 32'(err_count_o), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Three short frames after restart
    send(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      play(5);
      send(1'b1, 1'b0, 1'b0);
    end
    settle();
    chk("post_rst_locked", 32'(locked_o), 1);
`ifdef MSF_STATS_EN
    chk("err_count_3", 32'(err_count_o), 3);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
